// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Sklansky prefix adder.
package prefix_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int levels(input int w);
    return $clog2(w);
  endfunction

  function automatic int pipe_lat(input int w, input int pe);
    return (levels(w) + pe - 1) / pe + 1;
  endfunction

  // A register slice sits after level k unless k is the final level, which feeds the output stage.
  function automatic bit has_slice(input int k, input int lv, input int pe);
    return (k < lv) && (k % pe == 0);
  endfunction

endpackage

// File: rtl/pg_merge_cell.sv
// One prefix merge: combines a higher (hi) group with the adjacent lower (lo) group.
module pg_merge_cell
  import prefix_adder_pkg::*;
(
  input  pg_t hi,
  input  pg_t lo,
  output pg_t o
);

  assign o = '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Sklansky adder/subtractor with carry/overflow/zero flags and a tag sideband.
// Handshake: a beat transfers on a rising edge when valid and ready are both 1; one global stall (adv) moves every stage.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 1,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int LEVELS = levels(WIDTH);

  logic adv;
  logic rst_done_q;
  logic out_valid_q, out_valid_d;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv & rst_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done_q <= 1'b0;
    else        rst_done_q <= 1'b1;
  end

  // Signals at each level boundary; index 0 is the input register, LEVELS is the final prefix.
  pg_t [WIDTH-1:0]  lvl_pg  [LEVELS+1];
  logic [WIDTH-1:0] lvl_x   [LEVELS+1];
  logic             lvl_c0  [LEVELS+1];
  logic [TAG_W-1:0] lvl_tag [LEVELS+1];
  logic             lvl_vld [LEVELS+1];

  logic [WIDTH-1:0] b_eff;
  logic             c0_in;
  pg_t [WIDTH-1:0]  pg_in;

  pg_t [WIDTH-1:0]  pg0_d, pg0_q;
  logic [WIDTH-1:0] x0_d, x0_q;
  logic             c0_d, c0_q, vld0_d, vld0_q;
  logic [TAG_W-1:0] tag0_d, tag0_q;

  // Carry-in is folded into bit 0's generate, so every prefix G[i:0] already includes it.
  always_comb begin
    b_eff = sub ? ~b : b;
    c0_in = sub | cin;
    for (int i = 0; i < WIDTH; i++) begin
      pg_in[i].g = a[i] & b_eff[i];
      pg_in[i].p = a[i] | b_eff[i];
    end
    pg_in[0].g = pg_in[0].g | (pg_in[0].p & c0_in);
  end

  always_comb begin
    pg0_d  = pg0_q;
    x0_d   = x0_q;
    c0_d   = c0_q;
    tag0_d = tag0_q;
    vld0_d = vld0_q;
    if (adv) begin
      pg0_d  = pg_in;
      x0_d   = a ^ b_eff;
      c0_d   = c0_in;
      tag0_d = tag_in;
      vld0_d = in_valid & in_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg0_q  <= '0;
      x0_q   <= '0;
      c0_q   <= 1'b0;
      tag0_q <= '0;
      vld0_q <= 1'b0;
    end else begin
      pg0_q  <= pg0_d;
      x0_q   <= x0_d;
      c0_q   <= c0_d;
      tag0_q <= tag0_d;
      vld0_q <= vld0_d;
    end
  end

  assign lvl_pg[0]  = pg0_q;
  assign lvl_x[0]   = x0_q;
  assign lvl_c0[0]  = c0_q;
  assign lvl_tag[0] = tag0_q;
  assign lvl_vld[0] = vld0_q;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int SPAN = 1 << (k - 1);
    pg_t [WIDTH-1:0] mg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if ((i / SPAN) % 2 == 1) begin : g_merge
        pg_merge_cell u_cell (
          .hi(lvl_pg[k-1][i]),
          .lo(lvl_pg[k-1][(i / SPAN) * SPAN - 1]),
          .o (mg[i])
        );
      end else begin : g_pass
        assign mg[i] = lvl_pg[k-1][i];
      end
    end

    if (has_slice(k, LEVELS, PIPE_EVERY)) begin : g_slice
      pg_t [WIDTH-1:0]  pg_d, pg_q;
      logic [WIDTH-1:0] x_d, x_q;
      logic             c0_d, c0_q, vld_d, vld_q;
      logic [TAG_W-1:0] tag_d, tag_q;

      always_comb begin
        pg_d  = pg_q;
        x_d   = x_q;
        c0_d  = c0_q;
        tag_d = tag_q;
        vld_d = vld_q;
        if (adv) begin
          pg_d  = mg;
          x_d   = lvl_x[k-1];
          c0_d  = lvl_c0[k-1];
          tag_d = lvl_tag[k-1];
          vld_d = lvl_vld[k-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pg_q  <= '0;
          x_q   <= '0;
          c0_q  <= 1'b0;
          tag_q <= '0;
          vld_q <= 1'b0;
        end else begin
          pg_q  <= pg_d;
          x_q   <= x_d;
          c0_q  <= c0_d;
          tag_q <= tag_d;
          vld_q <= vld_d;
        end
      end

      assign lvl_pg[k]  = pg_q;
      assign lvl_x[k]   = x_q;
      assign lvl_c0[k]  = c0_q;
      assign lvl_tag[k] = tag_q;
      assign lvl_vld[k] = vld_q;
    end else begin : g_wire
      assign lvl_pg[k]  = mg;
      assign lvl_x[k]   = lvl_x[k-1];
      assign lvl_c0[k]  = lvl_c0[k-1];
      assign lvl_tag[k] = lvl_tag[k-1];
      assign lvl_vld[k] = lvl_vld[k-1];
    end
  end

  logic [WIDTH-1:0] carry, sum_n, sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  always_comb begin
    carry[0] = lvl_c0[LEVELS];
    for (int i = 1; i < WIDTH; i++) carry[i] = lvl_pg[LEVELS][i-1].g;
    sum_n = lvl_x[LEVELS] ^ carry;

    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    tag_d       = tag_q;
    if (adv) begin
      out_valid_d = lvl_vld[LEVELS];
      sum_d       = sum_n;
      cout_d      = lvl_pg[LEVELS][WIDTH-1].g;
      ovf_d       = carry[WIDTH-1] ^ lvl_pg[LEVELS][WIDTH-1].g;
      zero_d      = ~|sum_n;
      tag_d       = lvl_tag[LEVELS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      tag_q       <= tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: directed checks on a 32-bit/PIPE_EVERY=1 unit, then a
// concurrent random sweep of four width/pipelining configurations against an arithmetic model.
module tb_pipelined_prefix_adder;

  localparam int NC     = 4;
  localparam int NBEATS = 10000;
  localparam int CW  [NC] = '{8, 32, 64, 128};
  localparam int CPE [NC] = '{1, 5, 2, 3};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // clock/reset and main (32-bit, PIPE_EVERY=1) unit
  logic        m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready;
  logic        m_cout, m_ovf, m_zero;
  logic [31:0] m_a, m_b, m_sum;
  logic [3:0]  m_tag_in, m_tag_out;
  logic [134:0] m_obs;

  assign m_obs = {m_tag_out, m_zero, m_ovf, m_cout, 96'd0, m_sum};

  pipelined_prefix_adder #(.WIDTH(32), .PIPE_EVERY(1), .TAG_W(4)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub), .tag_in(m_tag_in),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .sum(m_sum),
    .cout(m_cout), .ovf(m_ovf), .zero(m_zero), .tag_out(m_tag_out)
  );

  // sweep units
  logic [127:0] s_a [NC];
  logic [127:0] s_b [NC];
  logic [127:0] s_sum [NC];
  logic         s_in_valid [NC];
  logic         s_in_ready [NC];
  logic         s_cin [NC];
  logic         s_sub [NC];
  logic         s_out_valid [NC];
  logic         s_out_ready [NC];
  logic         s_cout [NC];
  logic         s_ovf [NC];
  logic         s_zero [NC];
  logic [3:0]   s_tag_in [NC];
  logic [3:0]   s_tag_out [NC];

  for (genvar c = 0; c < NC; c++) begin : g_sw
    localparam int W = CW[c];
    logic [W-1:0] sum_w;
    pipelined_prefix_adder #(.WIDTH(W), .PIPE_EVERY(CPE[c]), .TAG_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[c]), .in_ready(s_in_ready[c]),
      .a(s_a[c][W-1:0]), .b(s_b[c][W-1:0]), .cin(s_cin[c]), .sub(s_sub[c]),
      .tag_in(s_tag_in[c]), .out_valid(s_out_valid[c]), .out_ready(s_out_ready[c]),
      .sum(sum_w), .cout(s_cout[c]), .ovf(s_ovf[c]), .zero(s_zero[c]),
      .tag_out(s_tag_out[c])
    );
    assign s_sum[c] = 128'(sum_w);
  end

  // scoreboard
  logic [134:0] exp_q [$];
  logic [134:0] sw_q [NC][$];

  function automatic logic [127:0] wmask(input int w);
    return (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
  endfunction

  function automatic logic signed [130:0] sext(input int w, input logic [127:0] v);
    logic [130:0] r;
    r = {3'b0, v};
    if (v[w-1]) r = r - (131'd1 << w);
    return signed'(r);
  endfunction

  // Reference: unsigned result/carry from plain arithmetic, overflow from the true signed result.
  function automatic logic [134:0] model(input int w, input logic [127:0] a, input logic [127:0] b,
                                         input logic cin, input logic sub, input logic [3:0] tag);
    logic [127:0] m, am, bm, s;
    logic [128:0] u;
    logic signed [130:0] sa, sb, r, lim;
    logic co, ov;
    m  = wmask(w);
    am = a & m;
    bm = b & m;
    if (sub) begin
      u  = {1'b0, am} - {1'b0, bm};
      co = (am >= bm);
    end else begin
      u  = {1'b0, am} + {1'b0, bm} + 129'(cin);
      co = (u > {1'b0, m});
    end
    s   = u[127:0] & m;
    sa  = sext(w, am);
    sb  = sext(w, bm);
    r   = sub ? (sa - sb) : (sa + sb + $signed({130'd0, cin}));
    lim = signed'(131'd1 << (w - 1));
    ov  = (r >= lim) || (r < -lim);
    return {tag, (s == 128'd0), ov, co, s};
  endfunction

  function automatic int exp_lat(input int w, input int pe);
    int l;
    l = 0;
    while ((1 << l) < w) l++;
    return (l + pe - 1) / pe + 1;
  endfunction

  function automatic logic [127:0] rnd_val(input int w);
    logic [127:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 128'd1 << (w - 1);
      3:       v = (128'd1 << (w - 1)) - 128'd1;
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v & wmask(w);
  endfunction

  task automatic chk(input string name, input logic [134:0] obs, input logic [134:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // driver: one isolated beat on the main unit, checking latency and result against literals
  task automatic m_beat(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [3:0] tag,
                        input logic [31:0] e_sum, input logic e_cout, input logic e_ovf,
                        input logic e_zero);
    int cnt;
    m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_tag_in = tag;
    m_in_valid = 1'b1;
    m_out_ready = 1'b1;
    #1;
    chk({name, "_in_ready"}, m_in_ready, 1);
    @(posedge clk); @(negedge clk);
    m_in_valid = 1'b0;
    cnt = 1;
    #1;
    while (!m_out_valid && cnt < 20) begin
      @(posedge clk); @(negedge clk); #1;
      cnt++;
    end
    chk({name, "_lat"}, cnt, 6);
    chk({name, "_data"}, m_obs, {tag, e_zero, e_ovf, e_cout, 96'd0, e_sum});
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [134:0] held, e;
    int sent, got, stall_left, cyc, cnt, extra;
    int lat [NC];
    int acc [NC];
    logic hold_pend [NC];
    logic [134:0] held_v [NC];
    logic [134:0] s_obs;
    logic done;

    rst_n = 1'b0;
    m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_tag_in = '0;
    m_out_ready = 1'b1;
    for (int c = 0; c < NC; c++) begin
      s_in_valid[c] = 1'b0; s_a[c] = '0; s_b[c] = '0; s_cin[c] = 1'b0; s_sub[c] = 1'b0;
      s_tag_in[c] = '0; s_out_ready[c] = 1'b1;
      acc[c] = 0; hold_pend[c] = 1'b0; held_v[c] = '0; lat[c] = 0;
    end

    // reset behaviour
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {m_out_valid, m_obs}, '0);
    chk("reset_in_ready", m_in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_clk", m_in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_first_clk", m_in_ready, 1);
    @(negedge clk);

    // directed arithmetic corners
    m_beat("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    m_beat("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h2, 32'h80000000, 1'b0, 1'b1, 1'b0);
    m_beat("add_cin",    32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 4'h3, 32'h80000000, 1'b0, 1'b1, 1'b0);
    m_beat("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 4'h4, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    m_beat("sub_ovf",    32'h80000000, 32'h00000001, 1'b1, 1'b1, 4'h5, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    m_beat("sub_equal",  32'h00000007, 32'h00000007, 1'b0, 1'b1, 4'h6, 32'h00000000, 1'b1, 1'b0, 1'b1);

    // streaming with a 3-cycle consumer stall from the first out_valid
    sent = 0; got = 0; stall_left = -1; cyc = 0;
    while (got < 8 && cyc < 100) begin
      m_in_valid = (sent < 8);
      m_a = 32'(sent) * 32'h11111111;
      m_b = 32'(sent) + 32'h0FFFFFFF;
      m_cin = sent[0];
      m_sub = 1'b0;
      m_tag_in = 4'(sent);
      if (m_out_valid && stall_left < 0) stall_left = 3;
      m_out_ready = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        chk("stream_in_ready_stall", m_in_ready, 0);
        chk("stream_valid_held", m_out_valid, 1);
        if (stall_left == 3) held = m_obs;
        else chk("stream_hold", m_obs, held);
      end
      if (m_in_valid && m_in_ready) begin
        exp_q.push_back(model(32, 128'(m_a), 128'(m_b), m_cin, m_sub, m_tag_in));
        sent++;
      end
      if (m_out_valid && m_out_ready) begin
        chk("stream_tag", m_tag_out, got);
        chk("stream_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("stream_data", m_obs, e);
        end
        got++;
      end
      if (stall_left > 0) stall_left--;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    chk("stream_count", got, 8);
    extra = 0;
    repeat (8) begin
      #1;
      if (m_out_valid) extra++;
      @(posedge clk); @(negedge clk);
    end
    chk("stream_no_duplicate", extra, 0);

    // reset with four beats in flight
    m_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_a = 32'(i) + 32'h100; m_b = 32'h5; m_cin = 1'b0; m_sub = 1'b0; m_tag_in = 4'(8 + i);
      m_in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    m_in_valid = 1'b0;
    cnt = 0;
    #1;
    while (!m_out_valid && cnt < 20) begin
      @(posedge clk); @(negedge clk); #1;
      cnt++;
    end
    chk("rst_prep_out_valid", m_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", m_out_valid, 0);
    chk("rst_async_outputs", m_obs, '0);
    chk("rst_async_in_ready", m_in_ready, 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    m_out_ready = 1'b1;
    extra = 0;
    repeat (12) begin
      #1;
      if (m_out_valid) extra++;
      @(posedge clk); @(negedge clk);
    end
    chk("rst_no_stale_beats", extra, 0);
    m_beat("post_rst", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 4'hC, 32'h2345678A, 1'b0, 1'b0, 1'b0);

    // sweep: isolated-beat latency per configuration
    for (int c = 0; c < NC; c++) begin
      s_a[c] = rnd_val(CW[c]); s_b[c] = rnd_val(CW[c]);
      s_cin[c] = 1'($urandom_range(0, 1)); s_sub[c] = 1'($urandom_range(0, 1));
      s_tag_in[c] = 4'($urandom_range(0, 15));
      s_in_valid[c] = 1'b1;
      s_out_ready[c] = 1'b1;
      sw_q[c].push_back(model(CW[c], s_a[c], s_b[c], s_cin[c], s_sub[c], s_tag_in[c]));
    end
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < NC; c++) s_in_valid[c] = 1'b0;
    for (cnt = 1; cnt <= 12; cnt++) begin
      #1;
      for (int c = 0; c < NC; c++) begin
        if (s_out_valid[c] && lat[c] == 0) begin
          lat[c] = cnt;
          s_obs = {s_tag_out[c], s_zero[c], s_ovf[c], s_cout[c], s_sum[c]};
          e = sw_q[c].pop_front();
          chk($sformatf("sw%0d_first_data", c), s_obs, e);
        end
      end
      @(posedge clk); @(negedge clk);
    end
    for (int c = 0; c < NC; c++)
      chk($sformatf("sw%0d_latency", c), lat[c], exp_lat(CW[c], CPE[c]));

    // sweep: random traffic and random backpressure on all four configurations at once
    cyc = 0;
    while (cyc < 60000) begin
      done = 1'b1;
      for (int c = 0; c < NC; c++)
        if (acc[c] < NBEATS || sw_q[c].size() != 0) done = 1'b0;
      if (done) break;
      for (int c = 0; c < NC; c++) begin
        s_in_valid[c] = (acc[c] < NBEATS) && ($urandom_range(0, 3) != 0);
        s_a[c] = rnd_val(CW[c]);
        s_b[c] = rnd_val(CW[c]);
        s_cin[c] = 1'($urandom_range(0, 1));
        s_sub[c] = 1'($urandom_range(0, 1));
        s_tag_in[c] = 4'($urandom_range(0, 15));
        s_out_ready[c] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int c = 0; c < NC; c++) begin
        s_obs = {s_tag_out[c], s_zero[c], s_ovf[c], s_cout[c], s_sum[c]};
        if (hold_pend[c]) begin
          chk($sformatf("sw%0d_hold_valid", c), s_out_valid[c], 1);
          chk($sformatf("sw%0d_hold_data", c), s_obs, held_v[c]);
        end
        hold_pend[c] = s_out_valid[c] && !s_out_ready[c];
        if (hold_pend[c]) begin
          held_v[c] = s_obs;
          chk($sformatf("sw%0d_in_ready_stall", c), s_in_ready[c], 0);
        end
        if (s_in_valid[c] && s_in_ready[c]) begin
          sw_q[c].push_back(model(CW[c], s_a[c], s_b[c], s_cin[c], s_sub[c], s_tag_in[c]));
          acc[c]++;
        end
        if (s_out_valid[c] && s_out_ready[c]) begin
          chk($sformatf("sw%0d_q_nonempty", c), sw_q[c].size() != 0, 1);
          if (sw_q[c].size() != 0) begin
            e = sw_q[c].pop_front();
            chk($sformatf("sw%0d_data", c), s_obs, e);
          end
        end
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    for (int c = 0; c < NC; c++) begin
      s_in_valid[c] = 1'b0;
      chk($sformatf("sw%0d_beats_accepted", c), acc[c], NBEATS);
      chk($sformatf("sw%0d_all_drained", c), sw_q[c].size(), 0);
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
